bist_sequencer: RTL and testbench
=================================

BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 Parameter PAT_CNT, default 64: number of test patterns applied per session, legal range 1..127.
REQ-002 Parameter FLUSH_CYC, default 1: extra enabled cycles after the last pattern so the final response enters the MISR, legal range 1..7.
REQ-003 Parameter GOLDEN_SIG, default 3'b101: expected 3-bit MISR signature.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level request; sampled only in IDLE.
REQ-007 abort  in  1  synchronous session cancel.
REQ-008 sig  in  3  current MISR signature.
REQ-009 tm  out  1  test-mode select; routes the LFSR vector to the counter under test.
REQ-010 clr  out  1  one-cycle synchronous clear pulse to the LFSR and MISR.
REQ-011 gen_en  out  1  advance enable for the LFSR and MISR.
REQ-012 busy  out  1  session in progress (any state except IDLE and DONE).
REQ-013 done  out  1  session complete; result valid.
REQ-014 pass  out  1  signature matched GOLDEN_SIG.
REQ-015 pat_cnt  out  7  number of patterns applied in the current or last session.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, RUN, FLUSH, CHECK and DONE; all outputs are registered or decoded directly from the state and counters.
REQ-017 IDLE: if start=1 at an edge, go to CLEAR; otherwise stay in IDLE; tm=0, gen_en=0, clr=0.
REQ-018 CLEAR: lasts 1 cycle with clr=1, tm=1, gen_en=0; pat_cnt is zeroed; next state is RUN.
REQ-019 RUN: lasts exactly PAT_CNT cycles with tm=1, gen_en=1; pat_cnt increments by 1 each cycle; go to FLUSH on the edge at which pat_cnt reaches PAT_CNT.
REQ-020 FLUSH: lasts FLUSH_CYC cycles with tm=1, gen_en=1; pat_cnt holds; next state is CHECK.
REQ-021 CHECK: lasts 1 cycle with gen_en=0, tm=1; pass is loaded with (sig == GOLDEN_SIG); next state is DONE.
REQ-022 DONE: done=1 and tm=0; stay in DONE while start=1; go to IDLE on the first edge with start=0.
REQ-023 Latency: done SHALL rise 1+PAT_CNT+FLUSH_CYC+1 edges after the edge that sampled start (67 edges at default parameters).
REQ-024 start asserted while busy=1 SHALL be ignored; start held high through DONE SHALL NOT launch a second session.
REQ-025 abort=1 in CLEAR, RUN, FLUSH or CHECK SHALL force IDLE at the next edge, with pass=0, done=0, gen_en=0 and tm=0; pat_cnt holds its last value.
REQ-026 abort SHALL be ignored in IDLE and DONE; if abort and start are both high in IDLE, start wins.
REQ-027 pass and pat_cnt SHALL keep their values in IDLE after a completed session; they change only in CLEAR, CHECK or on abort.
REQ-028 pat_cnt SHALL never exceed PAT_CNT (no wrap-around).
REQ-029 sig SHALL be sampled only in CHECK; changes on sig in any other state have no effect.

Reset
REQ-030 While reset=0, the block SHALL asynchronously enter IDLE with tm=0, clr=0, gen_en=0, busy=0, done=0, pass=0 and pat_cnt=0.
REQ-031 Reset asserted mid-session SHALL abandon the session; after release the block SHALL wait in IDLE for a new start.
REQ-032 Reset deassertion is synchronised externally; the block needs no internal reset synchroniser.

Structure
REQ-033 A shared BIST definitions file SHALL hold: the state encodings, the default PAT_CNT, FLUSH_CYC and GOLDEN_SIG, and the signature width (3).
REQ-034 One sub-module, bist_pat_counter, SHALL implement the clearable, enabled, saturating 7-bit pattern counter with a terminal-count flag.
REQ-035 bist_sequencer SHALL drive the tm, clr and gen_en inputs of the existing BIST controller datapath; it SHALL NOT instantiate the LFSR, MISR or counter under test.

Verification
REQ-036 Defaults, sig forced to 3'b101 during CHECK, 1-cycle start pulse -> clr high for 1 cycle, gen_en high for 65 cycles, done=1 and pass=1 at edge 67, pat_cnt=64.
REQ-037 Same stimulus but sig=3'b011 during CHECK -> done=1 at edge 67, pass=0.
REQ-038 abort pulsed at RUN cycle 10 -> IDLE next edge, pass=0, done never asserts, pat_cnt=10.
REQ-039 start held high for 100 cycles -> exactly one session; DONE held until start falls, then IDLE one edge later.
REQ-040 reset=0 applied at RUN cycle 30 -> all outputs zero immediately (asynchronously); after release, no activity until a new start.
REQ-041 PAT_CNT=1, FLUSH_CYC=3 -> gen_en high for 4 cycles, done at edge 6, pat_cnt=1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encodings, signature/counter widths
// and the default session parameters.
package bist_pkg;

  localparam int SIG_W = 3;
  localparam int CNT_W = 7;

  localparam int PAT_CNT_DEF   = 64;
  localparam int FLUSH_CYC_DEF = 1;
  localparam logic [SIG_W-1:0] GOLDEN_SIG_DEF = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } bist_state_t;

endpackage

// File: rtl/bist_pat_counter.sv
// Clearable, enabled, saturating pattern counter. The last flag marks the
// cycle in which the next increment reaches LIMIT, so the sequencer can
// leave RUN on the same edge that the count lands on LIMIT.
module bist_pat_counter
  import bist_pkg::*;
#(
  parameter int LIMIT = PAT_CNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST_V  = CNT_W'(LIMIT - 1);

  // Count applied patterns; hold once LIMIT is reached instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_V);

endmodule

// File: rtl/bist_sequencer.sv
// BIST session sequencer: drives tm/clr/gen_en of the BIST datapath, counts
// applied patterns, flushes the last response into the MISR and compares
// the resulting signature against GOLDEN_SIG.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; datapath in functional mode
//   S_CLEAR | one-cycle clear pulse to LFSR and MISR
//   S_RUN   | PAT_CNT cycles of pattern generation, pat_cnt counting
//   S_FLUSH | FLUSH_CYC extra enabled cycles so the last response lands
//   S_CHECK | one cycle, signature sampled into pass
//   S_DONE  | result valid; held until start is released
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int               PAT_CNT    = PAT_CNT_DEF,
  parameter int               FLUSH_CYC  = FLUSH_CYC_DEF,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = GOLDEN_SIG_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] sig,
  output logic             tm,
  output logic             clr,
  output logic             gen_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  bist_state_t state;
  logic [2:0]  flush_tmr;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_last;

  // Zero the count on the launching edge so it reads 0 throughout CLEAR;
  // an abort during RUN blocks the increment so the count freezes.
  assign cnt_clr = (state == S_IDLE) && start;
  assign cnt_en  = (state == S_RUN) && !abort;

  bist_pat_counter #(
    .LIMIT (PAT_CNT)
  ) u_pat_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (pat_cnt),
    .last  (cnt_last)
  );

  // Session FSM; all outputs are registered alongside the state so each
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      flush_tmr <= '0;
      tm        <= 1'b0;
      clr       <= 1'b0;
      gen_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      clr <= 1'b0;
      // busy is high in exactly CLEAR, RUN, FLUSH and CHECK
      if (abort && busy) begin
        state  <= S_IDLE;
        tm     <= 1'b0;
        gen_en <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
        pass   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_CLEAR;
              clr   <= 1'b1;
              tm    <= 1'b1;
              busy  <= 1'b1;
              pass  <= 1'b0;
            end
          end
          S_CLEAR: begin
            state  <= S_RUN;
            gen_en <= 1'b1;
          end
          S_RUN: begin
            if (cnt_last) begin
              state     <= S_FLUSH;
              flush_tmr <= FLUSH_LOAD;
            end
          end
          S_FLUSH: begin
            if (flush_tmr == 3'd0) begin
              state  <= S_CHECK;
              gen_en <= 1'b0;
            end else begin
              flush_tmr <= flush_tmr - 1'b1;
            end
          end
          S_CHECK: begin
            state <= S_DONE;
            pass  <= (sig == GOLDEN_SIG);
            done  <= 1'b1;
            tm    <= 1'b0;
            busy  <= 1'b0;
          end
          S_DONE: begin
            if (!start) begin
              state <= S_IDLE;
              done  <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            tm     <= 1'b0;
            gen_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: directed sessions with expected results pushed
// into per-DUT queues and checked by monitors when done rises.
module tb_bist_sequencer;

  typedef struct {
    int         cyc;
    logic       pass;
    logic [6:0] cnt;
    int         gen;
    int         clr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort;
  logic [2:0] sig;
  logic       tm, clr, gen_en, busy, done, pass;
  logic [6:0] pat_cnt;

  logic       start2, abort2;
  logic [2:0] sig2;
  logic       tm2, clr2, gen_en2, busy2, done2, pass2;
  logic [6:0] pat_cnt2;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   gen_cnt = 0, clr_cnt = 0, done_rises = 0;
  int   gen_cnt2 = 0, clr_cnt2 = 0;
  logic done_q = 1'b0, done2_q = 1'b0;
  exp_t exp_q[$];
  exp_t exp_q2[$];
  exp_t e, e2;

  bist_sequencer u_dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .sig     (sig),
    .tm      (tm),
    .clr     (clr),
    .gen_en  (gen_en),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .pat_cnt (pat_cnt)
  );

  bist_sequencer #(
    .PAT_CNT   (1),
    .FLUSH_CYC (3)
  ) u_dut2 (
    .clk     (clk),
    .reset   (reset),
    .start   (start2),
    .abort   (abort2),
    .sig     (sig2),
    .tm      (tm2),
    .clr     (clr2),
    .gen_en  (gen_en2),
    .busy    (busy2),
    .done    (done2),
    .pass    (pass2),
    .pat_cnt (pat_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the default-parameter DUT
  always @(negedge clk) begin
    if (gen_en) gen_cnt++;
    if (clr) clr_cnt++;
    if (done && !done_q) begin
      done_rises++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("pass", pass, e.pass);
        chk("pat_cnt", pat_cnt, e.cnt);
        chk("gen_en_cycles", gen_cnt, e.gen);
        chk("clr_cycles", clr_cnt, e.clr);
      end
    end
    done_q = done;
  end

  // Monitor for the PAT_CNT=1 / FLUSH_CYC=3 DUT
  always @(negedge clk) begin
    if (gen_en2) gen_cnt2++;
    if (clr2) clr_cnt2++;
    if (done2 && !done2_q) begin
      if (exp_q2.size() == 0) begin
        chk("unexpected_done2", 1, 0);
      end else begin
        e2 = exp_q2.pop_front();
        chk("done2_cycle", cyc, e2.cyc);
        chk("pass2", pass2, e2.pass);
        chk("pat_cnt2", pat_cnt2, e2.cnt);
        chk("gen_en2_cycles", gen_cnt2, e2.gen);
        chk("clr2_cycles", clr_cnt2, e2.clr);
      end
    end
    done2_q = done2;
  end

  // One full session on the default DUT; sig shows chk_sig only in CHECK.
  task automatic session(input logic [2:0] chk_sig, input logic exp_pass, input int hold);
    int s_edge;
    int span;
    @(negedge clk);
    start   = 1'b1;
    gen_cnt = 0;
    clr_cnt = 0;
    s_edge  = cyc + 1;
    sig     = ~chk_sig;
    exp_q.push_back('{s_edge + 67, exp_pass, 7'd64, 65, 1});
    span = (hold > 1 ? hold : 1) + 72;
    for (int i = 1; i <= span; i++) begin
      @(negedge clk);
      sig = (cyc == s_edge + 66) ? chk_sig : ~chk_sig;
      if (hold > 68 && i == hold) chk("done_held", done, 1);
      if (hold > 68 && i == hold + 1) begin
        chk("idle_after_release_done", done, 0);
        chk("idle_after_release_busy", busy, 0);
      end
      if (i == hold) start = 1'b0;
    end
    chk("no_second_session", busy, 0);
  endtask

  initial begin
    logic found;
    int   rises0;
    logic any_busy;
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    sig    = 3'b000;
    start2 = 1'b0;
    abort2 = 1'b0;
    sig2   = 3'b101;

    #12;
    chk("reset_outputs", {tm, clr, gen_en, busy, done, pass, pat_cnt}, 0);
    chk("reset_outputs2", {tm2, clr2, gen_en2, busy2, done2, pass2, pat_cnt2}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // PAT_CNT=1, FLUSH_CYC=3: done at edge 6, gen_en for 4 cycles
    start2   = 1'b1;
    gen_cnt2 = 0;
    clr_cnt2 = 0;
    exp_q2.push_back('{cyc + 1 + 6, 1'b1, 7'd1, 4, 1});
    @(negedge clk);
    start2 = 1'b0;
    repeat (10) @(negedge clk);

    // Matching signature, then mismatching signature
    session(3'b101, 1'b1, 1);
    repeat (5) @(negedge clk);
    chk("pass_kept_in_idle", pass, 1);
    chk("pat_cnt_kept_in_idle", pat_cnt, 64);
    session(3'b011, 1'b0, 1);

    // start held for 100 cycles: one session, DONE held until release
    session(3'b101, 1'b1, 100);

    // abort during RUN cycle 10
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && pat_cnt == 7'd10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach_run10", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_outputs", {tm, gen_en, busy, done, pass}, 0);
    chk("abort_pat_cnt", pat_cnt, 10);
    rises0 = done_rises;
    repeat (80) @(negedge clk);
    chk("abort_no_done", done_rises, rises0);
    chk("abort_pat_cnt_held", pat_cnt, 10);

    // start and abort together in IDLE: start wins; abort then hits CLEAR
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_beats_abort_busy", busy, 1);
    chk("start_beats_abort_clr", clr, 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_clear", {tm, gen_en, busy, done}, 0);
    chk("abort_in_clear_cnt", pat_cnt, 0);

    // reset at RUN cycle 30
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy && pat_cnt == 7'd30) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reset_reach_run30", found, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {tm, clr, gen_en, busy, done, pass, pat_cnt}, 0);
    @(negedge clk);
    reset = 1'b1;
    rises0   = done_rises;
    any_busy = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (busy || gen_en || tm) any_busy = 1'b1;
    end
    chk("no_activity_after_reset", any_busy, 0);
    chk("no_done_after_reset", done_rises, rises0);

    chk("scoreboard_empty", exp_q.size() + exp_q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
